// File: rtl/decode_stage_sequencer_if.sv
// Bundle of the requester-side handshake and the shared SRAM port.
// The sequencer owns the enables and the SRAM lines (master); the
// stages and the memory model sit on the slave side.
interface decode_stage_sequencer_if;
  logic        uart_done;
  logic        m2_done;
  logic        m1_done;
  logic [17:0] uart_address;
  logic [17:0] m2_address;
  logic [17:0] m1_address;
  logic [17:0] vga_address;
  logic [15:0] uart_write_data;
  logic [15:0] m2_write_data;
  logic [15:0] m1_write_data;
  logic        uart_we_n;
  logic        m2_we_n;
  logic        m1_we_n;
  logic        uart_enable;
  logic        m2_enable;
  logic        m1_enable;
  logic        vga_enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  uart_done, m2_done, m1_done,
    input  uart_address, m2_address, m1_address, vga_address,
    input  uart_write_data, m2_write_data, m1_write_data,
    input  uart_we_n, m2_we_n, m1_we_n,
    output uart_enable, m2_enable, m1_enable, vga_enable,
    output SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    output uart_done, m2_done, m1_done,
    output uart_address, m2_address, m1_address, vga_address,
    output uart_write_data, m2_write_data, m1_write_data,
    output uart_we_n, m2_we_n, m1_we_n,
    input  uart_enable, m2_enable, m1_enable, vga_enable,
    input  SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/decode_stage_sequencer.sv
// Top-level scheduler for the single external SRAM port of the image
// decompressor: UART load, IDCT (M2), upsample (M1), then VGA display,
// with fixed guard gaps between stages and a per-stage watchdog.
module decode_stage_sequencer #(
  parameter int               GAP_CYCLES     = 3,
  parameter int               CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd16000000
) (
  input  logic                            Clock,
  input  logic                            Resetn,
  input  logic                            Start,
  input  logic                            Abort,
  decode_stage_sequencer_if.master        bus,
  output logic                            busy,
  output logic                            error,
  output logic [2:0]                      stage_id
);

  typedef enum logic [3:0] {
    S_SEQ_IDLE  = 4'd0,
    S_SEQ_UART  = 4'd1,
    S_SEQ_GAP_A = 4'd2,
    S_SEQ_M2    = 4'd3,
    S_SEQ_GAP_B = 4'd4,
    S_SEQ_M1    = 4'd5,
    S_SEQ_GAP_C = 4'd6,
    S_SEQ_VGA   = 4'd7,
    S_SEQ_ERROR = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             error_next;
  logic             working;
  logic             in_gap;
  logic             timeout;
  logic             gap_end;

  // Next-state, sticky error and shared gap/watchdog counter; Abort beats timeout beats done beats Start.
  always_comb begin
    state_next = state;
    error_next = error;
    working    = (state == S_SEQ_UART) || (state == S_SEQ_M2) || (state == S_SEQ_M1);
    in_gap     = (state == S_SEQ_GAP_A) || (state == S_SEQ_GAP_B) || (state == S_SEQ_GAP_C);
    timeout    = working && (cnt == TIMEOUT_LAST);
    gap_end    = in_gap && (cnt == GAP_LAST);
    if (Abort) begin
      state_next = S_SEQ_IDLE;
    end else if (timeout) begin
      state_next = S_SEQ_ERROR;
      error_next = 1'b1;
    end else begin
      case (state)
        S_SEQ_IDLE, S_SEQ_ERROR: begin
          if (Start) begin
            state_next = S_SEQ_UART;
            error_next = 1'b0;
          end
        end
        S_SEQ_UART:  if (bus.uart_done) state_next = S_SEQ_GAP_A;
        S_SEQ_GAP_A: if (gap_end)       state_next = S_SEQ_M2;
        S_SEQ_M2:    if (bus.m2_done)   state_next = S_SEQ_GAP_B;
        S_SEQ_GAP_B: if (gap_end)       state_next = S_SEQ_M1;
        S_SEQ_M1:    if (bus.m1_done)   state_next = S_SEQ_GAP_C;
        S_SEQ_GAP_C: if (gap_end)       state_next = S_SEQ_VGA;
        S_SEQ_VGA:   state_next = S_SEQ_VGA;
        default:     state_next = S_SEQ_IDLE;
      endcase
    end
    // One counter serves both purposes: it restarts on every state change
    // and only runs in states where a gap or the watchdog is meaningful.
    if (state_next != state) begin
      cnt_next = '0;
    end else if (working || in_gap) begin
      cnt_next = cnt + CNT_W'(1);
    end else begin
      cnt_next = '0;
    end
  end

  // State, counter and error flag registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_SEQ_IDLE;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      error <= error_next;
    end
  end

  // Enables are registered from the next state so they rise with the stage and drop right after its done.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      bus.uart_enable <= 1'b0;
      bus.m2_enable   <= 1'b0;
      bus.m1_enable   <= 1'b0;
      bus.vga_enable  <= 1'b0;
    end else begin
      bus.uart_enable <= (state_next == S_SEQ_UART);
      bus.m2_enable   <= (state_next == S_SEQ_M2);
      bus.m1_enable   <= (state_next == S_SEQ_M1);
      bus.vga_enable  <= (state_next == S_SEQ_VGA);
    end
  end

  // SRAM ownership mux; idle/gap/error states park the port in read with address 0.
  always_comb begin
    bus.SRAM_address    = '0;
    bus.SRAM_write_data = '0;
    bus.SRAM_we_n       = 1'b1;
    case (state)
      S_SEQ_UART: begin
        bus.SRAM_address    = bus.uart_address;
        bus.SRAM_write_data = bus.uart_write_data;
        bus.SRAM_we_n       = bus.uart_we_n;
      end
      S_SEQ_M2: begin
        bus.SRAM_address    = bus.m2_address;
        bus.SRAM_write_data = bus.m2_write_data;
        bus.SRAM_we_n       = bus.m2_we_n;
      end
      S_SEQ_M1: begin
        bus.SRAM_address    = bus.m1_address;
        bus.SRAM_write_data = bus.m1_write_data;
        bus.SRAM_we_n       = bus.m1_we_n;
      end
      S_SEQ_VGA: begin
        bus.SRAM_address    = bus.vga_address;
      end
      default: begin
        bus.SRAM_address    = '0;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy     = (state != S_SEQ_IDLE) && (state != S_SEQ_ERROR);
    stage_id = (state == S_SEQ_ERROR) ? 3'd0 : state[2:0];
  end

endmodule

// File: tb/tb_decode_stage_sequencer.sv
// Bench for decode_stage_sequencer: vector table driven through a
// scoreboard queue, plus a hand-written mid-M1 asynchronous reset.
module tb_decode_stage_sequencer;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic       Abort;
  logic       busy;
  logic       error;
  logic [2:0] stage_id;

  int total = 0;
  int bad   = 0;
  int idx   = 0;

  localparam logic [17:0] UA  = 18'h00011;
  localparam logic [15:0] UD  = 16'h1111;
  localparam logic [17:0] M2A = 18'h22222;
  localparam logic [15:0] M2D = 16'h2222;
  localparam logic [17:0] M1A = 18'd146944;
  localparam logic [15:0] M1D = 16'hABCD;
  localparam logic [17:0] VA  = 18'h3FFFF;

  decode_stage_sequencer_if bus();

  decode_stage_sequencer #(
    .GAP_CYCLES(3),
    .CNT_W(24),
    .TIMEOUT_CYCLES(24'd50)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .Abort(Abort),
    .bus(bus),
    .busy(busy),
    .error(error),
    .stage_id(stage_id)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       start;
    logic       abort;
    logic       ud;
    logic       m2d;
    logic       m1d;
    logic [2:0] stage;
    logic [3:0] en;   // {vga, m1, m2, uart}
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  // Expected SRAM port {address, write data, we_n} for a given stage.
  function automatic logic [34:0] exp_sram(input logic [2:0] st);
    case (st)
      3'd1:    exp_sram = {UA, UD, 1'b0};
      3'd3:    exp_sram = {M2A, M2D, 1'b0};
      3'd5:    exp_sram = {M1A, M1D, 1'b0};
      3'd7:    exp_sram = {VA, 16'h0000, 1'b1};
      default: exp_sram = {18'd0, 16'h0000, 1'b1};
    endcase
  endfunction

  task automatic add(input int n, input logic s, input logic a, input logic u,
                     input logic m2, input logic m1, input logic [2:0] st,
                     input logic [3:0] en, input logic b, input logic e);
    vec_t v;
    v.start = s; v.abort = a; v.ud = u; v.m2d = m2; v.m1d = m1;
    v.stage = st; v.en = en; v.busy = b; v.err = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_ctrl(input string tag, input logic [2:0] st, input logic [3:0] en,
                            input logic b, input logic e);
    logic [8:0] got;
    logic [8:0] want;
    got  = {stage_id, bus.vga_enable, bus.m1_enable, bus.m2_enable, bus.uart_enable, busy, error};
    want = {st, en, b, e};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] ctrl {stage,en,busy,err} got=%b want=%b", tag, idx, got, want);
    end
  endtask

  task automatic check_sram(input string tag, input logic [2:0] st);
    logic [34:0] got;
    logic [34:0] want;
    got  = {bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n};
    want = exp_sram(st);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] sram {addr,data,we_n} got=%h want=%h", tag, idx, got, want);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    Start         = v.start;
    Abort         = v.abort;
    bus.uart_done = v.ud;
    bus.m2_done   = v.m2d;
    bus.m1_done   = v.m1d;
    exp_q.push_back(v);
    @(posedge Clock);
    #1;
    idx++;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty[%0d] got=0 entries want>=1", idx);
    end else begin
      e = exp_q.pop_front();
      check_ctrl("vec", e.stage, e.en, e.busy, e.err);
      check_sram("vec", e.stage);
    end
  endtask

  task automatic run_vectors();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    Resetn = 1'b0;
    Start = 1'b0; Abort = 1'b0;
    bus.uart_done = 1'b0; bus.m2_done = 1'b0; bus.m1_done = 1'b0;
    bus.uart_address = UA; bus.uart_write_data = UD; bus.uart_we_n = 1'b0;
    bus.m2_address = M2A;  bus.m2_write_data = M2D;  bus.m2_we_n = 1'b0;
    bus.m1_address = M1A;  bus.m1_write_data = M1D;  bus.m1_we_n = 1'b0;
    bus.vga_address = VA;

    #3;
    check_ctrl("reset", 3'd0, 4'b0000, 1'b0, 1'b0);
    check_sram("reset", 3'd0);
    #5 Resetn = 1'b1;
    @(posedge Clock);
    #1;

    // Full run with stray dones and Start while busy, then Abort from VGA.
    //    n  S  A  U  M2 M1 stage en       busy err
    add(1,  1, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(8,  0, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(1,  0, 0, 1, 0, 0, 3'd2, 4'b0000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd2, 4'b0000, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd3, 4'b0010, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd3, 4'b0010, 1, 0);
    add(1,  0, 0, 1, 0, 1, 3'd3, 4'b0010, 1, 0);
    add(1,  1, 0, 0, 0, 0, 3'd3, 4'b0010, 1, 0);
    add(1,  0, 0, 0, 1, 0, 3'd4, 4'b0000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd4, 4'b0000, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd5, 4'b0100, 1, 0);
    add(3,  0, 0, 0, 0, 0, 3'd5, 4'b0100, 1, 0);
    add(1,  0, 0, 0, 0, 1, 3'd6, 4'b0000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd6, 4'b0000, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd7, 4'b1000, 1, 0);
    add(1,  1, 0, 1, 1, 1, 3'd7, 4'b1000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd7, 4'b1000, 1, 0);
    add(1,  0, 1, 0, 0, 0, 3'd0, 4'b0000, 0, 0);
    // Watchdog: 50 UART cycles then ERROR; Abort in ERROR keeps error.
    add(1,  1, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(49, 0, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd0, 4'b0000, 0, 1);
    add(1,  0, 0, 0, 0, 0, 3'd0, 4'b0000, 0, 1);
    add(1,  0, 1, 0, 0, 0, 3'd0, 4'b0000, 0, 1);
    add(1,  1, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    // Timeout wins over a done pulse in the same cycle; Start from ERROR clears error.
    add(49, 0, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(1,  0, 0, 1, 0, 0, 3'd0, 4'b0000, 0, 1);
    add(1,  1, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    // Abort coincident with m2_done: back to IDLE, GAP_B never entered.
    add(1,  0, 0, 1, 0, 0, 3'd2, 4'b0000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd2, 4'b0000, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd3, 4'b0010, 1, 0);
    add(1,  0, 1, 0, 1, 0, 3'd0, 4'b0000, 0, 0);
    add(3,  0, 0, 0, 0, 0, 3'd0, 4'b0000, 0, 0);
    run_vectors();

    // Walk into M1, then pull Resetn low between clock edges.
    add(1,  1, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(1,  0, 0, 1, 0, 0, 3'd2, 4'b0000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd2, 4'b0000, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd3, 4'b0010, 1, 0);
    add(1,  0, 0, 0, 1, 0, 3'd4, 4'b0000, 1, 0);
    add(2,  0, 0, 0, 0, 0, 3'd4, 4'b0000, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd5, 4'b0100, 1, 0);
    run_vectors();
    Start = 1'b0;
    #2 Resetn = 1'b0;
    #1;
    check_ctrl("async_rst", 3'd0, 4'b0000, 1'b0, 1'b0);
    check_sram("async_rst", 3'd0);
    #2 Resetn = 1'b1;
    @(posedge Clock);
    #1;
    check_ctrl("post_rst", 3'd0, 4'b0000, 1'b0, 1'b0);
    check_sram("post_rst", 3'd0);
    add(1,  1, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    add(1,  0, 0, 0, 0, 0, 3'd1, 4'b0001, 1, 0);
    run_vectors();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_sequencer.md
Name: decode_stage_sequencer

Overview:
Top-level scheduler for the image decompressor's single external SRAM port. After Start, it runs the pipeline stages in a fixed order: UART image load, Milestone 2 (IDCT), Milestone 1 (YUV-to-RGB upsample), then VGA display. Each stage gets exclusive ownership of the SRAM address, write-data and write-enable lines. Stage handovers are separated by guard gaps so that in-flight SRAM reads drain.

Parameters:
GAP_CYCLES, 3, idle cycles between stages; SRAM forced to read, all enables low
TIMEOUT_CYCLES, 24'd16000000, maximum cycles allowed in any working stage before error
CNT_W, 24, width of the stage watchdog counter

Ports:
Clock  input  1  system clock
Resetn  input  1  asynchronous active-low reset
Start  input  1  one-cycle pulse; begins a decode run from S_SEQ_IDLE
Abort  input  1  one-cycle pulse; returns to S_SEQ_IDLE from any state
uart_done  input  1  pulse: UART load finished
m2_done  input  1  pulse: Milestone 2 finished
m1_done  input  1  pulse: Milestone 1 finished
uart_address / m2_address / m1_address / vga_address  input  18 each  requester SRAM address
uart_write_data / m2_write_data / m1_write_data  input  16 each  requester write data
uart_we_n / m2_we_n / m1_we_n  input  1 each  requester active-low write enable
uart_enable / m2_enable / m1_enable / vga_enable  output  1 each  stage run level, registered
SRAM_address  output  18  muxed SRAM address
SRAM_write_data  output  16  muxed SRAM write data
SRAM_we_n  output  1  muxed SRAM write enable
busy  output  1  high in every state except S_SEQ_IDLE and S_SEQ_ERROR
error  output  1  sticky watchdog timeout flag
stage_id  output  3  current state encoding, for debug LEDs

Behaviour:
- Reset values: all enables 0; SRAM_address 0; SRAM_write_data 0; SRAM_we_n 1; busy 0; error 0; state S_SEQ_IDLE; counters 0.
- State encoding: IDLE=0, UART=1, GAP_A=2, M2=3, GAP_B=4, M1=5, GAP_C=6, VGA=7. ERROR is a distinct internal state; stage_id reports 0 while in ERROR.
- Transitions:
  - IDLE → UART on Start. Start also clears error.
  - UART → GAP_A on uart_done.
  - GAP_A → M2 after GAP_CYCLES cycles.
  - M2 → GAP_B on m2_done.
  - GAP_B → M1 after GAP_CYCLES cycles.
  - M1 → GAP_C on m1_done.
  - GAP_C → VGA after GAP_CYCLES cycles.
  - VGA is terminal; it is left only by Abort.
- Enables: each enable is registered and high exactly while the state is the matching stage.
  - It rises in the first cycle of the stage.
  - It falls in the cycle after the done pulse is sampled.
- Done pulses are honoured only in the matching stage. Any other done input is ignored in all states.
- SRAM mux: combinational from the registered state.
  - UART/M2/M1: that requester's address, data and we_n.
  - VGA: vga_address, write data 0, we_n 1.
  - IDLE/GAP/ERROR: address 0, data 0, we_n 1.
  - A requester's we_n never reaches SRAM outside its own stage.
- Gap counter: loads 0 on entry to a gap and increments each cycle. Exit happens when count == GAP_CYCLES-1, so a gap lasts exactly GAP_CYCLES cycles. GAP_CYCLES=1 is legal (one cycle).
- Watchdog: counter clears on entry to UART/M2/M1 and increments each cycle in those states.
  - When count == TIMEOUT_CYCLES-1 without a done pulse, go to ERROR: error=1, enables low, SRAM idle.
  - ERROR → UART on Start, which clears error. Abort in ERROR → IDLE with error kept.
  - The watchdog is inactive in gaps and in VGA.
- Priority in the same cycle: Abort > timeout > done > Start.
  - A done pulse coincident with Abort is lost.
  - Start while busy is ignored.
- Abort mid-stage: the enable and SRAM write are cut in the next cycle. No gap is inserted; the next Start restarts at UART.
- Reset mid-operation: asynchronous return to reset values. The SRAM we_n is high immediately on Resetn low.

Test Plan:
- Reset, Start, then uart_done at cycle 10, m2_done at 20, m1_done at 30 (GAP_CYCLES=3) → stage_id steps 1,2,3,4,5,6,7. Enables are each exactly one stage wide; VGA is entered 3 cycles after m1_done is sampled.
- In stage M1, drive m1_address=18'd146944, m1_write_data=16'hABCD, m1_we_n=0 → SRAM shows the same values. In gap GAP_C with m1_we_n still 0 → SRAM_we_n=1 and address 0.
- Pulse m1_done and uart_done during M2 → no transition; m2_enable stays 1.
- TIMEOUT_CYCLES=50, no uart_done after Start → ERROR after 50 UART cycles with error=1 and all enables 0. Next Start → UART with error=0.
- Abort coincident with m2_done in M2 → IDLE next cycle, m2_enable=0, and GAP_B is never entered.
- Assert Resetn=0 mid-M1 with m1_we_n=0 → SRAM_we_n=1 and m1_enable=0 before the next Clock edge. On release, state is IDLE.
